// File: rtl/simplerisc_sync_mem.sv
`default_nettype none
// ============================================================================
// Module      : simplerisc_sync_mem
// Description : Clocked byte-addressed little-endian memory with a read-only
//               instruction port and a read/write data port. Each port has a
//               valid/ready request handshake, a registered response with
//               backpressure, and range/alignment error reporting.
//               Optional feature macro: SIMPLERISC_MEM_ALIGN_CHECK_EN
//               (when defined, addresses that are not word aligned are errors).
// Revision    : 1.0 - initial release
// ============================================================================
module simplerisc_sync_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // instruction port
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_resp_valid,
    input  logic                i_resp_ready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    // data port
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_resp_valid,
    input  logic                d_resp_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err
);

    localparam int              c_WB   = DATA_W / 8;
    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Last byte offset of a word and last legal byte address, one bit wider
    // than the address so addr + c_SPAN can never wrap.
    localparam logic [ADDR_W:0] c_SPAN = (ADDR_W + 1)'(c_WB - 1);
    localparam logic [ADDR_W:0] c_LAST = (ADDR_W + 1)'(DEPTH - 1);

    logic [7:0]        r_mem [DEPTH];

    logic              r_i_valid;
    logic              r_i_err;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_d_valid;
    logic              r_d_err;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_i_acc;
    logic              w_d_acc;
    logic              w_i_range_err;
    logic              w_d_range_err;
    logic              w_i_align_err;
    logic              w_d_align_err;
    logic              w_i_err;
    logic              w_d_err;
    logic [DATA_W-1:0] w_i_word;
    logic [DATA_W-1:0] w_d_word;
    logic [c_AW-1:0]   w_i_idx [c_WB];
    logic [c_AW-1:0]   w_d_idx [c_WB];

    // A response slot frees in the same cycle its contents are consumed.
    assign i_req_ready = !r_i_valid || i_resp_ready;
    assign d_req_ready = !r_d_valid || d_resp_ready;
    assign w_i_acc     = i_req_valid && i_req_ready;
    assign w_d_acc     = d_req_valid && d_req_ready;

    assign w_i_range_err = ({1'b0, i_addr} + c_SPAN) > c_LAST;
    assign w_d_range_err = ({1'b0, d_addr} + c_SPAN) > c_LAST;

`ifdef SIMPLERISC_MEM_ALIGN_CHECK_EN
    assign w_i_align_err = (i_addr % ADDR_W'(c_WB)) != '0;
    assign w_d_align_err = (d_addr % ADDR_W'(c_WB)) != '0;
`else
    assign w_i_align_err = 1'b0;
    assign w_d_align_err = 1'b0;
`endif

    assign w_i_err = w_i_range_err || w_i_align_err;
    assign w_d_err = w_d_range_err || w_d_align_err;

    // Byte lanes: lane k addresses addr+k. Indices are only meaningful when
    // the access is in range; erroring accesses never use them.
    for (genvar k = 0; k < c_WB; k++) begin : g_lanes
        assign w_i_idx[k]           = i_addr[c_AW-1:0] + c_AW'(k);
        assign w_d_idx[k]           = d_addr[c_AW-1:0] + c_AW'(k);
        assign w_i_word[8*k +: 8]   = r_mem[w_i_idx[k]];
        assign w_d_word[8*k +: 8]   = r_mem[w_d_idx[k]];
    end

    // Commit enabled bytes of an accepted, error-free write; array is never reset
    // and a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_d_acc && d_we && !w_d_err) begin
            for (int k = 0; k < c_WB; k++) begin
                if (d_be[k]) begin
                    r_mem[w_d_idx[k]] <= d_wdata[8*k +: 8];
                end
            end
        end
    end

    // Instruction response register; reads sample the array before any
    // same-edge data write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
        end else if (w_i_acc) begin
            r_i_valid <= 1'b1;
            r_i_err   <= w_i_err;
            r_i_rdata <= w_i_err ? '0 : w_i_word;
        end else if (i_resp_ready) begin
            r_i_valid <= 1'b0;
        end
    end

    // Data response register; writes answer with zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_valid <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;
        end else if (w_d_acc) begin
            r_d_valid <= 1'b1;
            r_d_err   <= w_d_err;
            r_d_rdata <= (w_d_err || d_we) ? '0 : w_d_word;
        end else if (d_resp_ready) begin
            r_d_valid <= 1'b0;
        end
    end

    assign i_resp_valid = r_i_valid;
    assign i_rdata      = r_i_rdata;
    assign i_err        = r_i_err;
    assign d_resp_valid = r_d_valid;
    assign d_rdata      = r_d_rdata;
    assign d_err        = r_d_err;

endmodule
`default_nettype wire
